// File: rtl/uart_rx_pkg.sv
// Shared UART definitions: receiver states, data width and baud divider helper.
package uart_rx_pkg;

    localparam int unsigned DATA_BITS = 8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_BREAK
    } rx_state_e;

    // Clock cycles per bit, rounded to nearest.
    function automatic int unsigned baud_divider(input int unsigned clock_hz,
                                                 input int unsigned baud);
        return (clock_hz + baud / 2) / baud;
    endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receive-side byte stream with sticky error flags and a busy indication.
interface uart_rx_if;
    import uart_rx_pkg::*;

    logic [DATA_BITS-1:0] data;
    logic                 valid;
    logic                 ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 clr_err;
    logic                 busy;

    modport master (
        output data, valid, frame_err, overrun, busy,
        input  ready, clr_err
    );

    modport slave (
        input  data, valid, frame_err, overrun, busy,
        output ready, clr_err
    );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for an asynchronous single-bit input.
module uart_rx_sync_2ff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clock,
    input  logic reset,
    input  logic d,
    output logic q
);

    logic meta_q;
    logic meta_d;
    logic sync_q;
    logic sync_d;

    // Shift the input through the two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Stage registers, preset to the line's resting value.
    always_ff @(posedge clock) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver: start-bit validation, centre sampling, stop check,
// and a valid/ready holding register with sticky frame/overrun flags.
module uart_rx
    import uart_rx_pkg::*;
#(
    parameter int unsigned Clock = 50000000,
    parameter int unsigned Baud  = 115200,
    parameter int unsigned Stop  = 1
) (
    input  logic     clock,
    input  logic     reset,
    input  logic     rxd,
    uart_rx_if.master rx
);

    localparam int unsigned DIVIDER = baud_divider(Clock, Baud);
    localparam int unsigned CNT_W   = $clog2(DIVIDER);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DIVIDER - 1);
    localparam logic [CNT_W-1:0] CNT_HALF  = CNT_W'(DIVIDER / 2 - 1);
    localparam logic [2:0]       IDX_LAST  = 3'(DATA_BITS - 1);
    localparam logic [2:0]       SIDX_LAST = 3'(Stop - 1);

    if (DIVIDER < 4) begin : g_div_check
        $error("uart_rx: baud divider %0d is below 4", DIVIDER);
    end

    if (Stop < 1 || Stop > 8) begin : g_stop_check
        $error("uart_rx: Stop=%0d outside 1..8", Stop);
    end

    logic                 rx_s;

    rx_state_e            state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [2:0]           idx_q, idx_d;
    logic [2:0]           sidx_q, sidx_d;
    logic [DATA_BITS-1:0] shreg_q, shreg_d;
    logic [DATA_BITS-1:0] data_q, data_d;
    logic                 valid_q, valid_d;
    logic                 frame_err_q, frame_err_d;
    logic                 overrun_q, overrun_d;
    logic                 busy_q, busy_d;

    logic                 deliver;
    logic                 stop_err;
    logic                 drop;

    uart_rx_sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d     (rxd),
        .q     (rx_s)
    );

    // Frame sequencing, holding-register handshake and error flag updates.
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        sidx_d      = sidx_q;
        shreg_d     = shreg_q;
        data_d      = data_q;
        valid_d     = valid_q;
        frame_err_d = frame_err_q;
        overrun_d   = overrun_q;
        deliver     = 1'b0;
        stop_err    = 1'b0;
        drop        = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (!rx_s) begin
                    state_d = ST_START;
                    cnt_d   = '0;
                end
            end
            ST_START: begin
                // Half a bit in: a line back high was only a glitch.
                if (cnt_q == CNT_HALF) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        state_d = ST_DATA;
                        idx_d   = '0;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_DATA: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d   = '0;
                    shreg_d = {rx_s, shreg_q[DATA_BITS-1:1]};
                    idx_d   = idx_q + 1'b1;
                    if (idx_q == IDX_LAST) begin
                        state_d = ST_STOP;
                        sidx_d  = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_STOP: begin
                if (cnt_q == CNT_LAST) begin
                    cnt_d = '0;
                    if (!rx_s) begin
                        stop_err = 1'b1;
                        state_d  = ST_BREAK;
                    end else if (sidx_q == SIDX_LAST) begin
                        // Return mid stop bit so the next start edge is caught.
                        deliver = 1'b1;
                        state_d = ST_IDLE;
                    end else begin
                        sidx_d = sidx_q + 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_BREAK: begin
                if (rx_s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (deliver) begin
            if (!valid_q || rx.ready) begin
                data_d  = shreg_q;
                valid_d = 1'b1;
            end else begin
                drop = 1'b1;
            end
        end else if (valid_q && rx.ready) begin
            valid_d = 1'b0;
        end

        // A new error in the same cycle as a clear keeps the flag set.
        if (rx.clr_err) begin
            frame_err_d = 1'b0;
            overrun_d   = 1'b0;
        end
        if (stop_err) begin
            frame_err_d = 1'b1;
        end
        if (drop) begin
            overrun_d = 1'b1;
        end

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            idx_q       <= '0;
            sidx_q      <= '0;
            shreg_q     <= '0;
            data_q      <= '0;
            valid_q     <= 1'b0;
            frame_err_q <= 1'b0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            sidx_q      <= sidx_d;
            shreg_q     <= shreg_d;
            data_q      <= data_d;
            valid_q     <= valid_d;
            frame_err_q <= frame_err_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
        end
    end

    assign rx.data      = data_q;
    assign rx.valid     = valid_q;
    assign rx.frame_err = frame_err_q;
    assign rx.overrun   = overrun_q;
    assign rx.busy      = busy_q;

endmodule

// File: tb/tb_uart_rx.sv
// Bench for uart_rx: frame-level event model plus directed literal checks.
module tb_uart_rx;
    import uart_rx_pkg::*;

    localparam int CLK_HZ    = 1600;
    localparam int BAUD      = 100;
    localparam int STOP      = 1;
    localparam int DIV       = 16;
    localparam int FAST_CLK  = 50000000;
    localparam int FAST_BAUD = 115200;
    localparam int DIV_FAST  = 434;
    // Cycles from driving the start edge to the stop-bit centre sample:
    // 2 synchroniser stages + 1 detect, half a bit, 8 data bits, STOP stop bits.
    localparam int LAT = 3 + DIV / 2 + DIV * (8 + STOP);

    typedef struct {
        int         cyc;
        bit         ferr;
        logic [7:0] data;
    } ev_t;

    logic clk      = 1'b0;
    logic reset    = 1'b1;
    logic rxd      = 1'b1;
    logic rxd_fast = 1'b1;

    always #5 clk = ~clk;

    uart_rx_if rx_if ();
    uart_rx_if fast_if ();

    uart_rx #(.Clock(CLK_HZ), .Baud(BAUD), .Stop(STOP)) u_dut (
        .clock (clk),
        .reset (reset),
        .rxd   (rxd),
        .rx    (rx_if)
    );

    uart_rx #(.Clock(FAST_CLK), .Baud(FAST_BAUD), .Stop(1)) u_dut_fast (
        .clock (clk),
        .reset (reset),
        .rxd   (rxd_fast),
        .rx    (fast_if)
    );

    int         cyc = 0;
    int         n_cmp = 0;
    int         n_bad = 0;
    ev_t        ev_q[$];
    logic       exp_valid = 1'b0;
    logic       exp_ferr  = 1'b0;
    logic       exp_ovr   = 1'b0;
    logic [7:0] exp_data  = 8'h00;

    logic       prev_valid = 1'b0;
    int         rise_cyc = 0;
    int         hi_cnt = 0;
    int         acc_cnt = 0;

    // Model: completed frames arrive at precomputed cycles; apply handshake rules.
    always @(posedge clk) begin
        ev_t e;
        bit  dlv, ferr_new, ovr_new;
        cyc = cyc + 1;
        if (reset) begin
            exp_valid = 1'b0;
            exp_ferr  = 1'b0;
            exp_ovr   = 1'b0;
            exp_data  = 8'h00;
            ev_q.delete();
        end else begin
            dlv = 0; ferr_new = 0; ovr_new = 0;
            e.cyc = 0; e.ferr = 0; e.data = 8'h00;
            if (ev_q.size() > 0 && ev_q[0].cyc == cyc) begin
                e = ev_q.pop_front();
                if (e.ferr) ferr_new = 1; else dlv = 1;
            end
            if (dlv) begin
                if (!exp_valid || rx_if.ready) begin
                    exp_data  = e.data;
                    exp_valid = 1'b1;
                end else begin
                    ovr_new = 1;
                end
            end else if (exp_valid && rx_if.ready) begin
                exp_valid = 1'b0;
            end
            if (rx_if.clr_err) begin
                exp_ferr = 1'b0;
                exp_ovr  = 1'b0;
            end
            if (ferr_new) exp_ferr = 1'b1;
            if (ovr_new)  exp_ovr  = 1'b1;
        end
    end

    // Compare DUT outputs against the model every cycle.
    always @(negedge clk) begin
        if (cyc >= 1) begin
            n_cmp = n_cmp + 1;
            if ({rx_if.valid, rx_if.frame_err, rx_if.overrun, rx_if.data} !==
                {exp_valid, exp_ferr, exp_ovr, exp_data}) begin
                n_bad = n_bad + 1;
                $display("FAIL cycle %0d outputs: got valid=%b ferr=%b ovr=%b data=%h, want valid=%b ferr=%b ovr=%b data=%h",
                         cyc, rx_if.valid, rx_if.frame_err, rx_if.overrun, rx_if.data,
                         exp_valid, exp_ferr, exp_ovr, exp_data);
            end
        end
    end

    // Observe valid edges and accepts for latency/pulse-width/count checks.
    always @(negedge clk) begin
        if (rx_if.valid === 1'b1 && prev_valid !== 1'b1) rise_cyc = cyc;
        if (rx_if.valid === 1'b1) hi_cnt = hi_cnt + 1;
        if (rx_if.valid === 1'b1 && rx_if.ready === 1'b1) acc_cnt = acc_cnt + 1;
        prev_valid = rx_if.valid;
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_cmp = n_cmp + 1;
        if (got !== want) begin
            n_bad = n_bad + 1;
            $display("FAIL %s: got %0h want %0h", name, got, want);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic set_line(input bit fast, input logic v);
        if (fast) rxd_fast = v;
        else      rxd = v;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit stop_low, input bit fast,
                              output int k);
        int  div;
        ev_t e;
        div = fast ? DIV_FAST : DIV;
        @(posedge clk);
        #1;
        k = cyc;
        if (!fast) begin
            e.cyc  = k + LAT;
            e.ferr = stop_low;
            e.data = b;
            ev_q.push_back(e);
        end
        set_line(fast, 1'b0);
        tick(div);
        for (int i = 0; i < 8; i++) begin
            set_line(fast, b[i]);
            tick(div);
        end
        set_line(fast, !stop_low);
        tick(div);
        set_line(fast, 1'b1);
    endtask

    task automatic pulse_ready_at_event();
        int e;
        @(posedge clk);
        #2;
        if (ev_q.size() == 0) begin
            check("t7_event_pending", 32'(ev_q.size()), 32'd1);
        end else begin
            e = ev_q[ev_q.size() - 1].cyc;
            while (cyc < e - 1) tick(1);
            rx_if.ready = 1'b1;
            tick(1);
            rx_if.ready = 1'b0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int  k, n0;
        ev_t ev;
        rx_if.ready     = 1'b0;
        rx_if.clr_err   = 1'b0;
        fast_if.ready   = 1'b0;
        fast_if.clr_err = 1'b0;
        reset = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2);

        check("reset_valid", 32'(rx_if.valid), 32'd0);
        check("reset_data",  32'(rx_if.data), 32'h00);
        check("reset_busy",  32'(rx_if.busy), 32'd0);
        check("reset_flags", 32'({rx_if.frame_err, rx_if.overrun}), 32'd0);

        // 1: single byte, consumer always ready
        rx_if.ready = 1'b1;
        hi_cnt = 0;
        send_frame(8'hA5, 1'b0, 1'b0, k);
        tick(4);
        check("t1_latency", 32'(rise_cyc - k), 32'd155);
        check("t1_pulse",   32'(hi_cnt), 32'd1);
        check("t1_data",    32'(rx_if.data), 32'hA5);
        check("t1_flags",   32'({rx_if.frame_err, rx_if.overrun}), 32'd0);

        // 2: two bytes with no consumer -> second is dropped
        rx_if.ready = 1'b0;
        send_frame(8'h3C, 1'b0, 1'b0, k);
        send_frame(8'hC3, 1'b0, 1'b0, k);
        tick(4);
        check("t2_data",    32'(rx_if.data), 32'h3C);
        check("t2_valid",   32'(rx_if.valid), 32'd1);
        check("t2_overrun", 32'(rx_if.overrun), 32'd1);

        // 7: accept coincides with delivery -> byte replaced, no new overrun
        fork
            send_frame(8'h77, 1'b0, 1'b0, k);
            pulse_ready_at_event();
        join
        tick(2);
        check("t7_data",  32'(rx_if.data), 32'h77);
        check("t7_valid", 32'(rx_if.valid), 32'd1);
        rx_if.ready   = 1'b1;
        rx_if.clr_err = 1'b1;
        tick(1);
        rx_if.ready   = 1'b0;
        rx_if.clr_err = 1'b0;
        tick(1);
        check("t7_drained", 32'({rx_if.valid, rx_if.overrun}), 32'd0);
        check("t7_held",    32'(rx_if.data), 32'h77);

        // 3: 4-cycle low glitch on idle line
        tick(1);
        k = cyc;
        rxd = 1'b0;
        tick(4);
        rxd = 1'b1;
        tick(2);
        check("t3_busy_mid", 32'(rx_if.busy), 32'd1);
        tick(10);
        check("t3_busy_end", 32'(rx_if.busy), 32'd0);
        check("t3_quiet",    32'({rx_if.valid, rx_if.frame_err}), 32'd0);
        tick(DIV);

        // 4: stop bit low -> framing error, then clear
        send_frame(8'h55, 1'b1, 1'b0, k);
        tick(4);
        check("t4_ferr",  32'(rx_if.frame_err), 32'd1);
        check("t4_valid", 32'(rx_if.valid), 32'd0);
        rx_if.clr_err = 1'b1;
        tick(1);
        rx_if.clr_err = 1'b0;
        check("t4_cleared", 32'(rx_if.frame_err), 32'd0);

        // 5: line held low 40 bit times; clear lands on the error cycle
        tick(1);
        k = cyc;
        ev.cyc = k + LAT; ev.ferr = 1'b1; ev.data = 8'h00;
        ev_q.push_back(ev);
        rxd = 1'b0;
        tick(LAT - 1);
        rx_if.clr_err = 1'b1;
        tick(1);
        rx_if.clr_err = 1'b0;
        check("t5_err_wins", 32'(rx_if.frame_err), 32'd1);
        tick(40 * DIV - LAT);
        rxd = 1'b1;
        tick(2 * DIV);
        check("t5_idle", 32'(rx_if.busy), 32'd0);
        rx_if.clr_err = 1'b1;
        tick(1);
        rx_if.clr_err = 1'b0;
        send_frame(8'h81, 1'b0, 1'b0, k);
        tick(4);
        check("t5_data", 32'({rx_if.valid, rx_if.data}), 32'h181);
        rx_if.ready = 1'b1;
        tick(1);
        rx_if.ready = 1'b0;

        // 6: reset during bit 4 of 0xFF, then 0x12
        tick(1);
        rxd = 1'b0;
        tick(DIV);
        rxd = 1'b1;
        tick(4 * DIV + DIV / 2);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(2 * DIV);
        check("t6_after_reset", 32'({rx_if.valid, rx_if.busy, rx_if.frame_err}), 32'd0);
        send_frame(8'h12, 1'b0, 1'b0, k);
        tick(4);
        check("t6_data", 32'({rx_if.valid, rx_if.data}), 32'h112);
        rx_if.ready = 1'b1;
        tick(1);

        // 6b: every byte value in order, consumer ready
        n0 = acc_cnt;
        for (int i = 0; i < 256; i++) begin
            send_frame(8'(i), 1'b0, 1'b0, k);
            tick(DIV);
        end
        tick(4);
        check("t6b_count", 32'(acc_cnt - n0), 32'd256);
        check("t6b_flags", 32'({rx_if.frame_err, rx_if.overrun}), 32'd0);
        rx_if.ready = 1'b0;

        // 50 MHz / 115200 instance
        check("fast_idle", 32'(fast_if.valid), 32'd0);
        send_frame(8'h5A, 1'b0, 1'b1, k);
        tick(4);
        check("fast_data",  32'({fast_if.valid, fast_if.data}), 32'h15A);
        check("fast_flags", 32'({fast_if.frame_err, fast_if.overrun}), 32'd0);

        tick(4);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
